// File: rtl/vx_om_mem_arb_pkg.sv
// Shared types and helpers for the OM memory-request arbiter.
// Contents:
//   OM_* localparams   lane count and field widths of OM pixel requests
//   om_tile_key_t      tile key {pos_y >> log, pos_x >> log} used for RAW hazard matching
//   om_rw_e            memory request direction (0 = read, 1 = write)
//   om_tile_key()      key of the lowest active lane (lane 0 when no lane is active)
package vx_om_mem_arb_pkg;

    localparam int OM_NUM_LANES    = 4;
    localparam int OM_DIM_BITS     = 11;
    localparam int OM_DEPTH_BITS   = 24;
    localparam int OM_STENCIL_BITS = 8;
    localparam int OM_KEY_W        = 2 * OM_DIM_BITS;

    typedef logic [OM_KEY_W-1:0] om_tile_key_t;

    typedef enum logic {
        OM_RW_READ  = 1'b0,
        OM_RW_WRITE = 1'b1
    } om_rw_e;

    function automatic om_tile_key_t om_tile_key(
        input logic [OM_NUM_LANES-1:0]             mask,
        input logic [OM_NUM_LANES*OM_DIM_BITS-1:0] pos_x,
        input logic [OM_NUM_LANES*OM_DIM_BITS-1:0] pos_y,
        input int                                  tile_logsize
    );
        int                     lane;
        logic [OM_DIM_BITS-1:0] x;
        logic [OM_DIM_BITS-1:0] y;
        lane = 0;
        // Walk downwards so the lowest set lane is the one that sticks.
        for (int i = OM_NUM_LANES - 1; i >= 0; i--) begin
            if (mask[i]) lane = i;
        end
        x = pos_x[lane*OM_DIM_BITS +: OM_DIM_BITS];
        y = pos_y[lane*OM_DIM_BITS +: OM_DIM_BITS];
        return {y >> tile_logsize, x >> tile_logsize};
    endfunction

endpackage

// File: rtl/vx_om_mem_arb_tracker.sv
// Pending-write tracker: circular FIFO of tile keys for writes granted but not yet
// acknowledged by memory, with a parallel compare against a read key.
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_push           record i_push_key (ignored when full)
//   i_pop            retire the oldest entry (ignored when empty)
//   i_push_key       key of the write being granted
//   i_cmp_key        key of the waiting read
//   o_match          i_cmp_key equals some valid entry
//   o_full           no free entry
module vx_om_mem_arb_tracker
    import vx_om_mem_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_push,
    input  logic         i_pop,
    input  om_tile_key_t i_push_key,
    input  om_tile_key_t i_cmp_key,
    output logic         o_match,
    output logic         o_full
);

    localparam int PTR_W = $clog2(DEPTH);

    om_tile_key_t     r_keys [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;

    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !w_empty;

    // Push and pop never touch the same slot: that would need full or empty,
    // and each of those blocks one of the two operations.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_vld   <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_vld[r_wptr] <= 1'b1;
                r_wptr        <= r_wptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_vld[r_rptr] <= 1'b0;
                r_rptr        <= r_rptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_keys[r_wptr] <= i_push_key;
    end

    always_comb begin
        o_match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && (r_keys[i] == i_cmp_key)) o_match = 1'b1;
        end
    end

    a_pop_empty: assert property (@(posedge i_clk) disable iff (i_reset) !(i_pop && w_empty));

endmodule

// File: rtl/vx_om_mem_arb.sv
// OM memory-request arbiter: merges the read port (depth/stencil/color fetch) and the
// write port (blend/depth writeback) onto one registered request to VX_om_mem.
// Reads are held back while a same-tile write is unacknowledged, and in-flight reads
// are bounded by a credit counter. Writes win unless a ready read has waited
// STARVE_MAX write grants.
// Ports:
//   i_clk, i_reset                 clock, synchronous active-high reset
//   i_rd_* / o_rd_ready            read request (masks, positions, face, tag)
//   i_wr_* / o_wr_ready            write request (as read plus color/depth/stencil)
//   o_mreq_* / i_mreq_ready        registered memory request, o_mreq_rw 1 = write
//   i_write_notify                 one pulse per write accepted by memory, in order
//   i_mrsp_fire                    read response handshake from memory
//   o_rd_pending                   reads granted but not yet answered
module vx_om_mem_arb
    import vx_om_mem_arb_pkg::*;
#(
    parameter int NUM_LANES    = OM_NUM_LANES,
    parameter int TAG_WIDTH    = 1,
    parameter int MAX_READS    = 8,
    parameter int WR_PEND_SIZE = 4,
    parameter int TILE_LOGSIZE = 1,
    parameter int STARVE_MAX   = 4,
    localparam int PEND_W      = $clog2(MAX_READS + 1),
    localparam int POS_W       = NUM_LANES * OM_DIM_BITS
) (
    input  logic                               i_clk,
    input  logic                               i_reset,

    input  logic                               i_rd_valid,
    output logic                               o_rd_ready,
    input  logic [NUM_LANES-1:0]               i_rd_ds_mask,
    input  logic [NUM_LANES-1:0]               i_rd_c_mask,
    input  logic [POS_W-1:0]                   i_rd_pos_x,
    input  logic [POS_W-1:0]                   i_rd_pos_y,
    input  logic [NUM_LANES-1:0]               i_rd_face,
    input  logic [TAG_WIDTH-1:0]               i_rd_tag,

    input  logic                               i_wr_valid,
    output logic                               o_wr_ready,
    input  logic [NUM_LANES-1:0]               i_wr_ds_mask,
    input  logic [NUM_LANES-1:0]               i_wr_c_mask,
    input  logic [POS_W-1:0]                   i_wr_pos_x,
    input  logic [POS_W-1:0]                   i_wr_pos_y,
    input  logic [NUM_LANES*32-1:0]            i_wr_color,
    input  logic [NUM_LANES*OM_DEPTH_BITS-1:0] i_wr_depth,
    input  logic [NUM_LANES*OM_STENCIL_BITS-1:0] i_wr_stencil,
    input  logic [NUM_LANES-1:0]               i_wr_face,
    input  logic [TAG_WIDTH-1:0]               i_wr_tag,

    output logic                               o_mreq_valid,
    input  logic                               i_mreq_ready,
    output logic                               o_mreq_rw,
    output logic [NUM_LANES-1:0]               o_mreq_ds_mask,
    output logic [NUM_LANES-1:0]               o_mreq_c_mask,
    output logic [POS_W-1:0]                   o_mreq_pos_x,
    output logic [POS_W-1:0]                   o_mreq_pos_y,
    output logic [NUM_LANES*32-1:0]            o_mreq_color,
    output logic [NUM_LANES*OM_DEPTH_BITS-1:0] o_mreq_depth,
    output logic [NUM_LANES*OM_STENCIL_BITS-1:0] o_mreq_stencil,
    output logic [NUM_LANES-1:0]               o_mreq_face,
    output logic [TAG_WIDTH-1:0]               o_mreq_tag,

    input  logic                               i_write_notify,
    input  logic                               i_mrsp_fire,
    output logic [PEND_W-1:0]                  o_rd_pending
);

    localparam int STV_W = $clog2(STARVE_MAX + 1);

    logic [PEND_W-1:0] r_rd_pending;
    logic [STV_W-1:0]  r_starve_cnt;

    logic                               r_mreq_valid_p1;
    logic                               r_mreq_rw_p1;
    logic [NUM_LANES-1:0]               r_mreq_ds_mask_p1;
    logic [NUM_LANES-1:0]               r_mreq_c_mask_p1;
    logic [POS_W-1:0]                   r_mreq_pos_x_p1;
    logic [POS_W-1:0]                   r_mreq_pos_y_p1;
    logic [NUM_LANES*32-1:0]            r_mreq_color_p1;
    logic [NUM_LANES*OM_DEPTH_BITS-1:0] r_mreq_depth_p1;
    logic [NUM_LANES*OM_STENCIL_BITS-1:0] r_mreq_stencil_p1;
    logic [NUM_LANES-1:0]               r_mreq_face_p1;
    logic [TAG_WIDTH-1:0]               r_mreq_tag_p1;

    om_tile_key_t w_rd_key;
    om_tile_key_t w_wr_key;
    logic         w_rd_hazard;
    logic         w_trk_full;
    logic         w_slot;
    logic         w_rd_ok;
    logic         w_wr_ok;
    logic         w_sel_rd;
    logic         w_rd_fire;
    logic         w_wr_fire;
    logic         w_mrsp_dec;

    // ---- p0: tile keys, hazard check, grant selection ----
    assign w_rd_key = om_tile_key(i_rd_ds_mask | i_rd_c_mask, i_rd_pos_x, i_rd_pos_y, TILE_LOGSIZE);
    assign w_wr_key = om_tile_key(i_wr_ds_mask | i_wr_c_mask, i_wr_pos_x, i_wr_pos_y, TILE_LOGSIZE);

    // Writes are pushed at grant time so the one sitting in the output register
    // already blocks same-tile reads.
    vx_om_mem_arb_tracker #(
        .DEPTH (WR_PEND_SIZE)
    ) u_tracker (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_push     (w_wr_fire),
        .i_pop      (i_write_notify),
        .i_push_key (w_wr_key),
        .i_cmp_key  (w_rd_key),
        .o_match    (w_rd_hazard),
        .o_full     (w_trk_full)
    );

    assign w_slot     = !r_mreq_valid_p1 || i_mreq_ready;
    assign w_rd_ok    = i_rd_valid && !w_rd_hazard && (r_rd_pending < PEND_W'(MAX_READS));
    assign w_wr_ok    = i_wr_valid && !w_trk_full;
    assign w_sel_rd   = w_rd_ok && (!w_wr_ok || (r_starve_cnt == STV_W'(STARVE_MAX)));
    assign w_rd_fire  = !i_reset && w_slot && w_sel_rd;
    assign w_wr_fire  = !i_reset && w_slot && w_wr_ok && !w_sel_rd;
    assign w_mrsp_dec = i_mrsp_fire && (r_rd_pending != '0);

    assign o_rd_ready   = w_rd_fire;
    assign o_wr_ready   = w_wr_fire;
    assign o_rd_pending = r_rd_pending;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mreq_valid_p1 <= 1'b0;
            r_rd_pending    <= '0;
            r_starve_cnt    <= '0;
        end else begin
            if (w_slot) r_mreq_valid_p1 <= w_rd_fire || w_wr_fire;

            case ({w_rd_fire, w_mrsp_dec})
                2'b10:   r_rd_pending <= r_rd_pending + PEND_W'(1);
                2'b01:   r_rd_pending <= r_rd_pending - PEND_W'(1);
                default: r_rd_pending <= r_rd_pending;
            endcase

            // Counts writes that overtook a ready read; saturates at STARVE_MAX.
            if (w_rd_fire || !w_rd_ok) begin
                r_starve_cnt <= '0;
            end else if (w_wr_fire && (r_starve_cnt != STV_W'(STARVE_MAX))) begin
                r_starve_cnt <= r_starve_cnt + STV_W'(1);
            end
        end
    end

    // ---- p1: output request register ----
    always_ff @(posedge i_clk) begin
        if (w_rd_fire) begin
            r_mreq_rw_p1      <= OM_RW_READ;
            r_mreq_ds_mask_p1 <= i_rd_ds_mask;
            r_mreq_c_mask_p1  <= i_rd_c_mask;
            r_mreq_pos_x_p1   <= i_rd_pos_x;
            r_mreq_pos_y_p1   <= i_rd_pos_y;
            r_mreq_color_p1   <= '0;
            r_mreq_depth_p1   <= '0;
            r_mreq_stencil_p1 <= '0;
            r_mreq_face_p1    <= i_rd_face;
            r_mreq_tag_p1     <= i_rd_tag;
        end else if (w_wr_fire) begin
            r_mreq_rw_p1      <= OM_RW_WRITE;
            r_mreq_ds_mask_p1 <= i_wr_ds_mask;
            r_mreq_c_mask_p1  <= i_wr_c_mask;
            r_mreq_pos_x_p1   <= i_wr_pos_x;
            r_mreq_pos_y_p1   <= i_wr_pos_y;
            r_mreq_color_p1   <= i_wr_color;
            r_mreq_depth_p1   <= i_wr_depth;
            r_mreq_stencil_p1 <= i_wr_stencil;
            r_mreq_face_p1    <= i_wr_face;
            r_mreq_tag_p1     <= i_wr_tag;
        end
    end

    assign o_mreq_valid   = r_mreq_valid_p1;
    assign o_mreq_rw      = r_mreq_rw_p1;
    assign o_mreq_ds_mask = r_mreq_ds_mask_p1;
    assign o_mreq_c_mask  = r_mreq_c_mask_p1;
    assign o_mreq_pos_x   = r_mreq_pos_x_p1;
    assign o_mreq_pos_y   = r_mreq_pos_y_p1;
    assign o_mreq_color   = r_mreq_color_p1;
    assign o_mreq_depth   = r_mreq_depth_p1;
    assign o_mreq_stencil = r_mreq_stencil_p1;
    assign o_mreq_face    = r_mreq_face_p1;
    assign o_mreq_tag     = r_mreq_tag_p1;

    a_rsp_underflow: assert property (@(posedge i_clk) disable iff (i_reset)
                                      !(i_mrsp_fire && (r_rd_pending == '0)));

endmodule

// File: tb/tb_vx_om_mem_arb.sv
module tb_vx_om_mem_arb;
    import vx_om_mem_arb_pkg::*;

    localparam int NL    = OM_NUM_LANES;
    localparam int DB    = OM_DIM_BITS;
    localparam int POS_W = NL * DB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                         reset;
    logic                         rd_valid, rd_ready;
    logic [NL-1:0]                rd_ds_mask, rd_c_mask, rd_face;
    logic [POS_W-1:0]             rd_pos_x, rd_pos_y;
    logic [0:0]                   rd_tag;
    logic                         wr_valid, wr_ready;
    logic [NL-1:0]                wr_ds_mask, wr_c_mask, wr_face;
    logic [POS_W-1:0]             wr_pos_x, wr_pos_y;
    logic [NL*32-1:0]             wr_color;
    logic [NL*OM_DEPTH_BITS-1:0]  wr_depth;
    logic [NL*OM_STENCIL_BITS-1:0] wr_stencil;
    logic [0:0]                   wr_tag;
    logic                         mreq_valid, mreq_ready, mreq_rw;
    logic [NL-1:0]                mreq_ds_mask, mreq_c_mask, mreq_face;
    logic [POS_W-1:0]             mreq_pos_x, mreq_pos_y;
    logic [NL*32-1:0]             mreq_color;
    logic [NL*OM_DEPTH_BITS-1:0]  mreq_depth;
    logic [NL*OM_STENCIL_BITS-1:0] mreq_stencil;
    logic [0:0]                   mreq_tag;
    logic                         write_notify, mrsp_fire;
    logic [3:0]                   rd_pending;

    vx_om_mem_arb dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_rd_valid     (rd_valid),
        .o_rd_ready     (rd_ready),
        .i_rd_ds_mask   (rd_ds_mask),
        .i_rd_c_mask    (rd_c_mask),
        .i_rd_pos_x     (rd_pos_x),
        .i_rd_pos_y     (rd_pos_y),
        .i_rd_face      (rd_face),
        .i_rd_tag       (rd_tag),
        .i_wr_valid     (wr_valid),
        .o_wr_ready     (wr_ready),
        .i_wr_ds_mask   (wr_ds_mask),
        .i_wr_c_mask    (wr_c_mask),
        .i_wr_pos_x     (wr_pos_x),
        .i_wr_pos_y     (wr_pos_y),
        .i_wr_color     (wr_color),
        .i_wr_depth     (wr_depth),
        .i_wr_stencil   (wr_stencil),
        .i_wr_face      (wr_face),
        .i_wr_tag       (wr_tag),
        .o_mreq_valid   (mreq_valid),
        .i_mreq_ready   (mreq_ready),
        .o_mreq_rw      (mreq_rw),
        .o_mreq_ds_mask (mreq_ds_mask),
        .o_mreq_c_mask  (mreq_c_mask),
        .o_mreq_pos_x   (mreq_pos_x),
        .o_mreq_pos_y   (mreq_pos_y),
        .o_mreq_color   (mreq_color),
        .o_mreq_depth   (mreq_depth),
        .o_mreq_stencil (mreq_stencil),
        .o_mreq_face    (mreq_face),
        .o_mreq_tag     (mreq_tag),
        .i_write_notify (write_notify),
        .i_mrsp_fire    (mrsp_fire),
        .o_rd_pending   (rd_pending)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [POS_W-1:0] rep(input int v);
        logic [DB-1:0] f;
        f = v[DB-1:0];
        return {NL{f}};
    endfunction

    function automatic logic [NL*32-1:0] color_of(input int v);
        logic [7:0] b;
        b = v[7:0];
        return {NL{b, b, b, b}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic v, input int x, input int y);
        rd_valid   = v;
        rd_ds_mask = 4'b0001;
        rd_c_mask  = 4'b0000;
        rd_pos_x   = rep(x);
        rd_pos_y   = rep(y);
        rd_face    = '0;
        rd_tag     = 1'b0;
    endtask

    task automatic set_wr(input logic v, input int x, input int y);
        wr_valid   = v;
        wr_ds_mask = 4'b0001;
        wr_c_mask  = 4'b0001;
        wr_pos_x   = rep(x);
        wr_pos_y   = rep(y);
        wr_color   = color_of(x);
        wr_depth   = {NL{24'(x)}};
        wr_stencil = {NL{8'(y)}};
        wr_face    = 4'b1010;
        wr_tag     = 1'b1;
    endtask

    task automatic idle();
        set_rd(1'b0, 0, 0);
        set_wr(1'b0, 0, 0);
        write_notify = 1'b0;
        mrsp_fire    = 1'b0;
    endtask

    logic [1:0] t2_exp [6];

    initial begin
        // ---- reset: a waiting read must not be acknowledged ----
        reset      = 1'b1;
        mreq_ready = 1'b1;
        idle();
        rd_valid = 1'b1;
        repeat (2) step();
        check("rst_mvld", mreq_valid, 1'b0);
        check("rst_pend", rd_pending, 4'd0);
        check("rst_rdy", {rd_ready, wr_ready}, 2'b00);
        rd_valid = 1'b0;
        reset    = 1'b0;

        // ---- 1: single read at (0,0) ----
        set_rd(1'b1, 0, 0);
        #1 check("t1_rdy", rd_ready, 1'b1);
        step();
        set_rd(1'b0, 0, 0);
        check("t1_vld", mreq_valid, 1'b1);
        check("t1_rw", mreq_rw, 1'b0);
        check("t1_pend", rd_pending, 4'd1);
        mrsp_fire = 1'b1;
        step();
        mrsp_fire = 1'b0;
        check("t1_pend0", rd_pending, 4'd0);
        check("t1_vld0", mreq_valid, 1'b0);

        // ---- 2: starvation relief, write tile (0,0) vs read tile (4,4) ----
        t2_exp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
        set_rd(1'b1, 8, 8);
        set_wr(1'b1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            write_notify = (i >= 1 && i <= 4);
            #1 check($sformatf("t2_gnt%0d", i), {rd_ready, wr_ready}, t2_exp[i]);
            step();
        end
        idle();
        write_notify = 1'b1;
        mrsp_fire    = 1'b1;
        step();
        idle();
        check("t2_pend", rd_pending, 4'd0);

        // ---- 3: read-after-write hazard on tile (1,1) ----
        set_wr(1'b1, 2, 2);
        #1 check("t3_wgnt", wr_ready, 1'b1);
        step();
        set_wr(1'b0, 0, 0);
        set_rd(1'b1, 3, 3);
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("t3_hold%0d", i), rd_ready, 1'b0);
            step();
        end
        write_notify = 1'b1;
        #1 check("t3_hold_n", rd_ready, 1'b0);
        step();
        write_notify = 1'b0;
        #1 check("t3_rel", rd_ready, 1'b1);
        step();
        set_rd(1'b0, 0, 0);
        set_wr(1'b1, 2, 2);
        #1 check("t3_wgnt2", wr_ready, 1'b1);
        step();
        set_wr(1'b0, 0, 0);
        set_rd(1'b1, 4, 4);
        #1 check("t3_other", rd_ready, 1'b1);
        step();
        idle();
        write_notify = 1'b1;
        mrsp_fire    = 1'b1;
        step();
        write_notify = 1'b0;
        step();
        mrsp_fire = 1'b0;
        check("t3_pend", rd_pending, 4'd0);

        // ---- 4: read credit limit ----
        set_rd(1'b1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            #1 check($sformatf("t4_rdy%0d", i), rd_ready, 1'b1);
            step();
        end
        check("t4_pend8", rd_pending, 4'd8);
        check("t4_block", rd_ready, 1'b0);
        mrsp_fire = 1'b1;
        #1 check("t4_block_r", rd_ready, 1'b0);
        step();
        mrsp_fire = 1'b0;
        check("t4_pend7", rd_pending, 4'd7);
        #1 check("t4_credit", rd_ready, 1'b1);
        step();
        set_rd(1'b0, 0, 0);
        check("t4_pend8b", rd_pending, 4'd8);
        mrsp_fire = 1'b1;
        repeat (8) step();
        mrsp_fire = 1'b0;
        check("t4_drain", rd_pending, 4'd0);

        // ---- 5: output backpressure holds the request ----
        mreq_ready = 1'b0;
        set_wr(1'b1, 5, 6);
        #1 check("t5_wgnt", wr_ready, 1'b1);
        step();
        set_wr(1'b1, 9, 9);
        set_rd(1'b1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("t5_rdy%0d", i), {rd_ready, wr_ready}, 2'b00);
            check($sformatf("t5_vld%0d", i), mreq_valid, 1'b1);
            check($sformatf("t5_px%0d", i), mreq_pos_x, rep(5));
            check($sformatf("t5_col%0d", i), mreq_color, color_of(5));
            check($sformatf("t5_rw%0d", i), mreq_rw, 1'b1);
            step();
        end
        mreq_ready = 1'b1;
        #1 check("t5_rel", {rd_ready, wr_ready}, 2'b01);
        step();
        idle();
        check("t5_px_new", mreq_pos_x, rep(9));
        check("t5_dep_new", mreq_depth, {NL{24'd9}});
        check("t5_face", mreq_face, 4'b1010);
        write_notify = 1'b1;
        repeat (2) step();
        write_notify = 1'b0;

        // ---- 6: tracker full, push+pop, mid-run reset ----
        for (int i = 0; i < 4; i++) begin
            set_wr(1'b1, 20 + 2 * i, 0);
            #1 check($sformatf("t6_w%0d", i), wr_ready, 1'b1);
            step();
        end
        #1 check("t6_full", wr_ready, 1'b0);
        write_notify = 1'b1;
        step();
        #1 check("t6_pushpop", wr_ready, 1'b1);
        step();
        write_notify = 1'b0;
        #1 check("t6_three", wr_ready, 1'b1);
        step();
        set_rd(1'b1, 40, 40);
        #1 check("t6_full_rd", {rd_ready, wr_ready}, 2'b10);
        step();
        set_rd(1'b0, 0, 0);
        check("t6_pend", rd_pending, 4'd1);
        check("t6_vld", mreq_valid, 1'b1);
        reset = 1'b1;
        step();
        check("t6_rst_vld", mreq_valid, 1'b0);
        check("t6_rst_pend", rd_pending, 4'd0);
        check("t6_rst_rdy", wr_ready, 1'b0);
        reset = 1'b0;
        #1 check("t6_empty", wr_ready, 1'b1);
        step();
        idle();
        write_notify = 1'b1;
        step();
        write_notify = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1);
    end

endmodule
